dff_bank_arbiter: RTL and testbench
===================================

# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit D-flip-flop register bank. Up to N requesters compete for the bank. The block grants one requester at a time, latches that requester's data into the bank on the following clock, and returns a one-cycle acknowledge. It sits between the requesters and the shared register and is the only writer of that register.

## Interface
- N, default 4: number of requesters, minimum 2.
- WIDTH, default 8: width of the shared register.
- clk  input  1  rising-edge clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester write request, level-sensitive.
- wdata  input  N*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N  registered one-hot grant.
- ack  output  N  registered one-hot write-done pulse, one cycle wide.
- q  output  WIDTH  shared register contents.
- owner  output  $clog2(N)  index of the last requester whose write committed.
- busy  output  1  high while in GRANT.

## Operation
- Two states, IDLE and GRANT.
- IDLE:
  - If any req bit is 1, pick a winner in round-robin order, starting at ptr+1 and wrapping mod N.
  - Set gnt to the winner's one-hot, record the winner index, go to GRANT.
  - If req is all zero, stay in IDLE with gnt = 0.
- GRANT (always exactly one cycle):
  - If req[winner] = 1: q <= wdata[winner], ack <= one-hot(winner), owner <= winner, ptr <= winner.
  - If req[winner] = 0 (requester withdrew): abort. q, owner and ptr are unchanged and ack stays 0.
  - In both cases gnt <= 0 and the state returns to IDLE.
- ack is 0 in every cycle other than the one that follows a commit.
- A requester that sees ack must drop req before the next edge. If it does not, the block treats the still-high req as a new request, ranked lowest because ptr now points at it.
- Requests raised while in GRANT are ignored until the next IDLE evaluation. There is no queueing; req must be held.
- wdata is sampled only at the committing edge. Changes at any other time have no effect.
- Reset (asynchronous, rst_n = 0): state IDLE, gnt 0, ack 0, busy 0, q 0, owner 0, ptr N-1, so requester 0 has first priority.
- If rst_n falls while in GRANT, the write is discarded immediately and q is forced to 0.

## Timing
- Request sampled at edge E1. gnt and busy are high from E1 to E2.
- Commit happens at E2. q, owner and ack update at E2, and ack is high from E2 to E3.
- Request-to-q latency is 2 edges. Maximum throughput is one write every 2 cycles.
- gnt and ack are never high in the same cycle, and at most one bit of each is set.
- Starvation bound: a requester holding req is granted within N arbitration rounds, i.e. at most 2N cycles.
- Deassertion of rst_n is synchronous to clk through the normal register path. The first arbitration happens at the first edge with rst_n = 1.

## Structure
- Shared package dff_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - a function for the index width, $clog2(N);
  - the reset values (Q_RST = 0, PTR_RST = N-1).
- Sub-module rr_priority_pick is purely combinational:
  - inputs: req[N], ptr;
  - outputs: a one-hot winner, its index, and a valid flag.
  - The top level registers its outputs.
- The shared register lives inside this block, implemented as WIDTH D flip-flops with async clear, which drive q.

## Test plan
- Single requester (N=4, WIDTH=8): reset, then req = 4'b0010 with wdata[1] = 8'hA5 held until ack. Expect gnt = 0010 for 1 cycle, then q = 8'hA5, ack = 0010, owner = 1.
- All requesters: req = 4'b1111 held continuously, wdata[i] = 8'h10+i. Expect commits in order 0,1,2,3,0, with q stepping 10,11,12,13,10 every 2 cycles.
- Withdrawal: req[2] pulses high for exactly one cycle. Expect gnt = 0100, no ack, q and owner unchanged, and the next grant still starts search from the old ptr+1.
- Fairness after the pointer moves: after a commit by requester 3, raise req = 4'b1001 simultaneously. Expect the grant to go to 0 first, then 3.
- Reset mid-operation: assert rst_n = 0 while in GRANT with q = 8'h3C. Expect q = 0, gnt = 0, ack = 0, owner = 0 immediately without waiting for a clock edge, and no commit after release.
- Late wdata change: change wdata[0] while gnt = 0001 but before the commit edge. Expect q to equal the value present at the commit edge.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared types and reset constants for the round-robin DFF bank arbiter.
package dff_arb_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam int unsigned Q_RST = 0;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer resets to the last requester so requester 0 wins first.
    function automatic int unsigned ptr_rst(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping mod N.
module rr_priority_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int unsigned w_pos;

    // Scan farthest-first so the closest candidate after i_ptr overwrites the rest.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = 0;
        for (int k = N; k >= 1; k--) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (i_req[IW'(w_pos)]) begin
                o_onehot = N'(1) << w_pos;
                o_idx    = IW'(w_pos);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer; sole writer of the shared WIDTH-bit register.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IW    = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     q,
    output logic [IW-1:0]        owner,
    output logic                 busy
);

    arb_state_e       r_state;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     r_ack;
    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_win;

    logic [N-1:0]     w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_req_win;
    logic [WIDTH-1:0] w_wdata_win;
    logic             w_commit;

    rr_priority_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_req_win   = 1'b0;
        w_wdata_win = '0;
        for (int i = 0; i < N; i++) begin
            if (r_win == IW'(i)) begin
                w_req_win   = req[i];
                w_wdata_win = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant only commits if the winner still holds its request.
    assign w_commit = (r_state == StGrant) && w_req_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_owner <= '0;
            r_ptr   <= IW'(ptr_rst(N));
            r_win   <= '0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_gnt   <= w_pick_onehot;
                        r_win   <= w_pick_idx;
                        r_state <= StGrant;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                StGrant: begin
                    r_gnt   <= '0;
                    r_state <= StIdle;
                    if (w_commit) begin
                        r_ack   <= r_gnt;
                        r_owner <= r_win;
                        r_ptr   <= r_win;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // The shared register bank: plain DFFs with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= WIDTH'(Q_RST);
        end else if (w_commit) begin
            r_q <= w_wdata_win;
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign owner = r_owner;
    assign busy  = (r_state == StGrant);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter with N=4, WIDTH=8.
module tb_dff_bank_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic [WIDTH-1:0] q;
    logic [1:0]       owner;
    logic             busy;

    int errors = 0;
    int checks = 0;

    dff_bank_arbiter #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = '0;
        wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        wdata[1*8 +: 8] = 8'hA5;
        req = 4'b0010;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_early got=%b exp=0000", ack); end
        step();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q got=%h exp=a5", q); end
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack got=%b exp=0010", ack); end
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL single_owner got=%0d exp=1", owner); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_clr got=%b exp=0000", gnt); end
        req = 4'b0000;
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_all_requesters();
        logic [1:0] exp_seq [5];
        logic [3:0] oh;
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << exp_seq[k];
            step();
            checks++; if (gnt !== oh) begin errors++; $display("FAIL all_gnt[%0d] got=%b exp=%b", k, gnt, oh); end
            step();
            checks++; if (q !== 8'h10 + 8'(exp_seq[k])) begin errors++; $display("FAIL all_q[%0d] got=%h exp=%h", k, q, 8'h10 + 8'(exp_seq[k])); end
            checks++; if (ack !== oh) begin errors++; $display("FAIL all_ack[%0d] got=%b exp=%b", k, ack, oh); end
            checks++; if (owner !== exp_seq[k]) begin errors++; $display("FAIL all_owner[%0d] got=%0d exp=%0d", k, owner, exp_seq[k]); end
        end
        req = 4'b0000;
        step();
    endtask

    // Entry state: ptr=0, q=10, owner=0.
    task automatic test_withdraw();
        req = 4'b0100;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wd_gnt got=%b exp=0100", gnt); end
        req = 4'b0000;
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wd_ack got=%b exp=0000", ack); end
        checks++; if (q !== 8'h10) begin errors++; $display("FAIL wd_q got=%h exp=10", q); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL wd_owner got=%0d exp=0", owner); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wd_gnt_clr got=%b exp=0000", gnt); end
        // Old ptr=0 picks 2 over 3; a wrongly advanced ptr=2 would pick 3.
        req = 4'b1100;
        step();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wd_regrant got=%b exp=0100", gnt); end
        step();
        checks++; if (q !== 8'h12) begin errors++; $display("FAIL wd_commit_q got=%h exp=12", q); end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL wd_commit_owner got=%0d exp=2", owner); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_fairness();
        req = 4'b1000;
        step();
        step();
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL fair_pre_owner got=%0d exp=3", owner); end
        req = 4'b1001;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL fair_first got=%b exp=0001", gnt); end
        step();
        checks++; if (q !== 8'h10) begin errors++; $display("FAIL fair_first_q got=%h exp=10", q); end
        step();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL fair_second got=%b exp=1000", gnt); end
        step();
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL fair_second_owner got=%0d exp=3", owner); end
        checks++; if (q !== 8'h13) begin errors++; $display("FAIL fair_second_q got=%h exp=13", q); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_late_wdata();
        wdata[0 +: 8] = 8'h44;
        req = 4'b0001;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL late_gnt got=%b exp=0001", gnt); end
        wdata[0 +: 8] = 8'h77;
        step();
        checks++; if (q !== 8'h77) begin errors++; $display("FAIL late_q got=%h exp=77", q); end
        req = 4'b0000;
        wdata[0 +: 8] = 8'h99;
        step();
        checks++; if (q !== 8'h77) begin errors++; $display("FAIL late_hold got=%h exp=77", q); end
    endtask

    task automatic test_reset_mid();
        wdata[1*8 +: 8] = 8'h3C;
        wdata[2*8 +: 8] = 8'h55;
        req = 4'b0010;
        step();
        step();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL rmid_pre_q got=%h exp=3c", q); end
        req = 4'b0100;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_in_grant got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        req = 4'b0000;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rmid_q got=%h exp=00", q); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt got=%b exp=0000", gnt); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rmid_ack got=%b exp=0000", ack); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rmid_owner got=%0d exp=0", owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rmid_post_q got=%h exp=00", q); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rmid_post_ack got=%b exp=0000", ack); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_post_gnt got=%b exp=0000", gnt); end
        // Fresh reset pointer gives requester 0 first priority.
        req = 4'b0101;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_first_prio got=%b exp=0001", gnt); end
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesters();
        test_withdraw();
        test_fairness();
        test_late_wdata();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
